// File: rtl/alu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// control state encoding and flag bit positions.
package alu_pkg;

  localparam logic [1:0] OP_UMUL = 2'b00;
  localparam logic [1:0] OP_SMUL = 2'b01;
  localparam logic [1:0] OP_UDIV = 2'b10;
  localparam logic [1:0] OP_SDIV = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_RUN   = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/cond_negate.sv
// Conditional two's complement: result = neg ? -value : value.
module cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide: radix-2 shift-add multiplier and restoring divider
// sharing one adder. Handshake: start is accepted only in IDLE, busy is high
// from the next cycle through the done cycle, done pulses once with results valid.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic [3:0]       flags,
  output state_t           dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               res_sign;
  logic               rem_sign;

  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   neg_a_in;
  logic [WIDTH-1:0]   neg_b_in;
  logic               neg_a_en;
  logic               neg_b_en;
  logic [WIDTH-1:0]   neg_a_out;
  logic [WIDTH-1:0]   neg_b_out;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH:0]     add_x;
  logic [WIDTH:0]     add_y;
  logic               add_cin;
  logic [WIDTH+1:0]   add_sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [3:0]         fix_flags;
  logic [3:0]         dz_flags;

  assign is_div    = op_r[1];
  assign is_signed = op_r[0];
  assign dbg_state = state;

  // The two W-bit negators form magnitudes in PREP and fix quotient/remainder
  // signs in FIXUP; the product needs its own double-width negator.
  always_comb begin
    neg_a_in = a_r;
    neg_b_in = b_r;
    neg_a_en = is_signed & a_r[WIDTH-1];
    neg_b_en = is_signed & b_r[WIDTH-1];
    if (state == S_FIXUP) begin
      neg_a_in = acc[WIDTH-1:0];
      neg_b_in = acc[2*WIDTH-1:WIDTH];
      neg_a_en = (op_r == OP_SDIV) & res_sign;
      neg_b_en = (op_r == OP_SDIV) & rem_sign;
    end
  end

  cond_negate #(.W(WIDTH)) u_neg_a (
    .value  (neg_a_in),
    .neg    (neg_a_en),
    .result (neg_a_out)
  );

  cond_negate #(.W(WIDTH)) u_neg_b (
    .value  (neg_b_in),
    .neg    (neg_b_en),
    .result (neg_b_out)
  );

  cond_negate #(.W(2*WIDTH)) u_neg_p (
    .value  (acc),
    .neg    ((op_r == OP_SMUL) & res_sign),
    .result (prod)
  );

  // Shared adder: add multiplicand for multiply, subtract divisor (via ~b + 1)
  // for divide; the top bit of the sum is then "remainder >= divisor".
  always_comb begin
    add_x   = {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_y   = acc[0] ? {1'b0, mag_a} : '0;
    add_cin = 1'b0;
    if (is_div) begin
      add_x   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      add_y   = ~{1'b0, mag_b};
      add_cin = 1'b1;
    end
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};

  always_comb begin
    acc_next = {add_sum[WIDTH:0], acc[WIDTH-1:1]};
    if (is_div) begin
      acc_next = {(add_sum[WIDTH+1] ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0]),
                  acc[WIDTH-2:0], add_sum[WIDTH+1]};
    end
  end

  always_comb begin
    fix_flags = 4'b0000;
    dz_flags  = 4'b0000;
    dz_flags[FLAG_N] = 1'b1;
    if (is_div) begin
      fix_flags[FLAG_N] = neg_a_out[WIDTH-1];
      fix_flags[FLAG_Z] = (neg_a_out == '0);
      fix_flags[FLAG_V] = (op_r == OP_SDIV) && (a_r == MOST_NEG) && (b_r == '1);
    end else begin
      fix_flags[FLAG_N] = prod[2*WIDTH-1];
      fix_flags[FLAG_Z] = (prod == '0);
      if (op_r == OP_UMUL) begin
        fix_flags[FLAG_V] = (prod[2*WIDTH-1:WIDTH] != '0);
      end else begin
        fix_flags[FLAG_V] = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      mag_a       <= '0;
      mag_b       <= '0;
      acc         <= '0;
      cnt         <= '0;
      res_sign    <= 1'b0;
      rem_sign    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
      flags       <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            busy  <= 1'b1;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          mag_a    <= neg_a_out;
          mag_b    <= neg_b_out;
          res_sign <= is_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          rem_sign <= is_signed & a_r[WIDTH-1];
          cnt      <= '0;
          if (is_div && (b_r == '0)) begin
            acc         <= '0;
            result_lo   <= '1;
            result_hi   <= a_r;
            div_by_zero <= 1'b1;
            flags       <= dz_flags;
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            // Low half holds the multiplier, or the dividend that shifts out as quotient.
            acc   <= {{WIDTH{1'b0}}, (is_div ? neg_a_out : neg_b_out)};
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH-1)) begin
            state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          if (is_div) begin
            result_lo <= neg_a_out;
            result_hi <= neg_b_out;
          end else begin
            result_lo <= prod[WIDTH-1:0];
            result_hi <= prod[2*WIDTH-1:WIDTH];
          end
          flags       <= fix_flags;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq at WIDTH=32 and WIDTH=8: arithmetic reference model
// plus cycle-latency model, checked every cycle, with literal pinned cases.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start8;
  logic [1:0]  op32, op8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;

  logic        busy32, done32, dz32;
  logic [31:0] lo32, hi32;
  logic [3:0]  fl32;
  state_t      dbg32;
  logic        busy8, done8, dz8;
  logic [7:0]  lo8, hi8;
  logic [3:0]  fl8;
  state_t      dbg8;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Cycle model state, index 0 = WIDTH 32, index 1 = WIDTH 8.
  int          m_phase[2];
  int          m_lat[2];
  logic        m_busy[2];
  logic        m_done[2];
  logic [63:0] m_lo[2];
  logic [63:0] m_hi[2];
  logic [3:0]  m_fl[2];
  logic        m_dz[2];
  logic [63:0] p_lo[2];
  logic [63:0] p_hi[2];
  logic [3:0]  p_fl[2];
  logic        p_dz[2];

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result_lo(lo32), .result_hi(hi32),
    .div_by_zero(dz32), .flags(fl32), .dbg_state(dbg32)
  );

  alu_muldiv_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result_lo(lo8), .result_hi(hi8),
    .div_by_zero(dz8), .flags(fl8), .dbg_state(dbg8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void model(input int w, input logic [1:0] o, input logic [63:0] x,
                                input logic [63:0] y, output logic [63:0] lo,
                                output logic [63:0] hi, output logic [3:0] fl,
                                output logic dz);
    logic [63:0] mask, xa, yb, p, q, r, msb;
    longint sx, sy, ps, most_neg;
    logic n, z, v;
    mask = (64'd1 << w) - 64'd1;
    msb  = 64'd1 << (w - 1);
    xa = x & mask;
    yb = y & mask;
    sx = $signed(xa << (64 - w)) >>> (64 - w);
    sy = $signed(yb << (64 - w)) >>> (64 - w);
    most_neg = -(longint'(1) << (w - 1));
    n = 1'b0; z = 1'b0; v = 1'b0; dz = 1'b0;
    lo = '0; hi = '0;
    if (!o[1]) begin
      if (o == OP_UMUL) p = xa * yb;
      else begin
        ps = sx * sy;
        p = ps;
      end
      lo = p & mask;
      hi = (p >> w) & mask;
      n = (hi & msb) != 0;
      z = (p == 0);
      if (o == OP_UMUL) v = (hi != 0);
      else v = (hi != (((lo & msb) != 0) ? mask : 64'd0));
    end else begin
      if (yb == 0) begin
        q = mask;
        r = xa;
        dz = 1'b1;
      end else if (o == OP_UDIV) begin
        q = xa / yb;
        r = xa % yb;
      end else if (sx == most_neg && sy == -1) begin
        q = msb;
        r = 0;
        v = 1'b1;
      end else begin
        q = 64'(sx / sy);
        r = 64'(sx % sy);
      end
      lo = q & mask;
      hi = r & mask;
      n = (lo & msb) != 0;
      z = (lo == 0);
    end
    fl = {n, z, 1'b0, v};
  endfunction

  task automatic step_model(input int k, input logic s, input logic [1:0] o,
                            input logic [63:0] x, input logic [63:0] y);
    int w;
    w = (k == 1) ? 8 : 32;
    if (!reset) begin
      m_phase[k] = 0; m_busy[k] = 1'b0; m_done[k] = 1'b0;
      m_lo[k] = '0; m_hi[k] = '0; m_fl[k] = '0; m_dz[k] = 1'b0;
    end else if (m_phase[k] == 0) begin
      m_done[k] = 1'b0;
      if (s) begin
        model(w, o, x, y, p_lo[k], p_hi[k], p_fl[k], p_dz[k]);
        m_lat[k] = p_dz[k] ? 2 : w + 3;
        m_phase[k] = 1;
        m_busy[k] = 1'b1;
      end
    end else if (m_phase[k] == m_lat[k]) begin
      m_phase[k] = 0; m_busy[k] = 1'b0; m_done[k] = 1'b0;
    end else begin
      m_phase[k]++;
      if (m_phase[k] == m_lat[k]) begin
        m_done[k] = 1'b1;
        m_lo[k] = p_lo[k]; m_hi[k] = p_hi[k]; m_fl[k] = p_fl[k]; m_dz[k] = p_dz[k];
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_lat[k] = 0; m_busy[k] = 0; m_done[k] = 0;
      m_lo[k] = 0; m_hi[k] = 0; m_fl[k] = 0; m_dz[k] = 0;
    end
  end

  always @(posedge clk) begin
    step_model(0, start32, op32, 64'(a32), 64'(b32));
    step_model(1, start8, op8, 64'(a8), 64'(b8));
  end

  // Compare process: handshake every cycle, results whenever idle or done.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy32", 64'(busy32), 64'(m_busy[0]));
      check("done32", 64'(done32), 64'(m_done[0]));
      check("busy8", 64'(busy8), 64'(m_busy[1]));
      check("done8", 64'(done8), 64'(m_done[1]));
      if (!m_busy[0] || m_done[0]) begin
        check("lo32", 64'(lo32), m_lo[0]);
        check("hi32", 64'(hi32), m_hi[0]);
        check("flags32", 64'(fl32), 64'(m_fl[0]));
        check("dz32", 64'(dz32), 64'(m_dz[0]));
      end
      if (!m_busy[1] || m_done[1]) begin
        check("lo8", 64'(lo8), m_lo[1]);
        check("hi8", 64'(hi8), m_hi[1]);
        check("flags8", 64'(fl8), 64'(m_fl[1]));
        check("dz8", 64'(dz8), 64'(m_dz[1]));
      end
    end
  end

  task automatic drive(input bit is8, input logic s, input logic [1:0] o,
                       input logic [63:0] x, input logic [63:0] y);
    if (is8) begin
      start8 = s; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      start32 = s; op32 = o; a32 = x[31:0]; b32 = y[31:0];
    end
  endtask

  function automatic logic get_done(input bit is8);
    return is8 ? done8 : done32;
  endfunction

  // Launch one op; optionally pulse start or reset at a given cycle number.
  task automatic run_op(input bit is8, input logic [1:0] o, input logic [63:0] x,
                        input logic [63:0] y, input int glitch_cyc, input int rst_cyc,
                        output logic [63:0] lo, output logic [63:0] hi,
                        output logic [3:0] fl, output logic dz, output int lat);
    int cyc;
    bit rst_hit;
    lo = '0; hi = '0; fl = '0; dz = 1'b0; lat = -1; rst_hit = 1'b0;
    drive(is8, 1'b1, o, x, y);
    @(negedge clk);
    drive(is8, 1'b0, o, x, y);
    cyc = 1;
    while (cyc < 300) begin
      if (get_done(is8) || rst_hit) break;
      if (cyc == glitch_cyc) drive(is8, 1'b1, ~o, ~x, ~y);
      if (cyc == rst_cyc) begin
        reset = 1'b0;
        rst_hit = 1'b1;
      end
      @(negedge clk);
      cyc++;
      drive(is8, 1'b0, o, x, y);
      reset = 1'b1;
    end
    if (rst_hit) return;
    if (!get_done(is8)) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: no done within %0d cycles", cyc);
      return;
    end
    lat = cyc;
    lo = is8 ? 64'(lo8) : 64'(lo32);
    hi = is8 ? 64'(hi8) : 64'(hi32);
    fl = is8 ? fl8 : fl32;
    dz = is8 ? dz8 : dz32;
    @(negedge clk);
  endtask

  function automatic logic [63:0] pick(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return mask;
      3: return 64'd1 << (w - 1);
      default: return {$urandom(), $urandom()} & mask;
    endcase
  endfunction

  initial begin
    logic [63:0] lo, hi, mlo, mhi;
    logic [3:0]  fl, mfl;
    logic        dz, mdz;
    int          lat, dones;
    bit          is8;
    logic [1:0]  o;
    logic [63:0] x, y;

    reset = 1'b0;
    start32 = 0; op32 = 0; a32 = 0; b32 = 0;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0;
    @(negedge clk);
    chk_en = 1'b1;
    check("reset busy", 64'(busy32), 64'd0);
    check("reset done", 64'(done32), 64'd0);
    check("reset lo", 64'(lo32), 64'd0);
    check("reset flags", 64'(fl32), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Pin the model itself on hand-computed values.
    model(8, OP_SMUL, 64'hFD, 64'h07, mlo, mhi, mfl, mdz);
    check("model smul8 lo", mlo, 64'hEB);
    check("model smul8 hi", mhi, 64'hFF);
    model(32, OP_SDIV, 64'hFFFFFFF9, 64'd2, mlo, mhi, mfl, mdz);
    check("model sdiv32 q", mlo, 64'hFFFFFFFD);
    check("model sdiv32 r", mhi, 64'hFFFFFFFF);

    run_op(0, OP_SMUL, 64'hFFFFFFFD, 64'd7, -1, -1, lo, hi, fl, dz, lat);
    check("smul32 hi", hi, 64'hFFFFFFFF);
    check("smul32 lo", lo, 64'hFFFFFFEB);
    check("smul32 flags", 64'(fl), 64'b1000);
    check("smul32 latency", 64'(lat), 64'd35);

    run_op(0, OP_UMUL, 64'hFFFFFFFF, 64'hFFFFFFFF, -1, -1, lo, hi, fl, dz, lat);
    check("umul32 hi", hi, 64'hFFFFFFFE);
    check("umul32 lo", lo, 64'h1);
    check("umul32 flags", 64'(fl), 64'b1001);

    run_op(0, OP_UMUL, 64'd0, 64'd5, -1, -1, lo, hi, fl, dz, lat);
    check("umul zero lo", lo, 64'd0);
    check("umul zero flags", 64'(fl), 64'b0100);

    run_op(0, OP_UDIV, 64'd100, 64'd7, 10, -1, lo, hi, fl, dz, lat);
    check("udiv q (start while busy)", lo, 64'hE);
    check("udiv r (start while busy)", hi, 64'h2);
    check("udiv latency", 64'(lat), 64'd35);

    run_op(0, OP_SDIV, 64'hFFFFFFF9, 64'd2, -1, -1, lo, hi, fl, dz, lat);
    check("sdiv32 q", lo, 64'hFFFFFFFD);
    check("sdiv32 r", hi, 64'hFFFFFFFF);
    check("sdiv32 flags", 64'(fl), 64'b1000);

    run_op(0, OP_UDIV, 64'd5, 64'd0, -1, -1, lo, hi, fl, dz, lat);
    check("div0 q", lo, 64'hFFFFFFFF);
    check("div0 r", hi, 64'd5);
    check("div0 flag", 64'(dz), 64'd1);
    check("div0 latency", 64'(lat), 64'd2);

    run_op(0, OP_SDIV, 64'h80000000, 64'hFFFFFFFF, -1, -1, lo, hi, fl, dz, lat);
    check("sdiv ovf q", lo, 64'h80000000);
    check("sdiv ovf r", hi, 64'd0);
    check("sdiv ovf V", 64'(fl[FLAG_V]), 64'd1);

    run_op(1, OP_SMUL, 64'hFD, 64'h07, -1, -1, lo, hi, fl, dz, lat);
    check("smul8 hi", hi, 64'hFF);
    check("smul8 lo", lo, 64'hEB);
    check("smul8 latency", 64'(lat), 64'd11);

    run_op(1, OP_SDIV, 64'hF9, 64'h02, -1, -1, lo, hi, fl, dz, lat);
    check("sdiv8 q", lo, 64'hFD);
    check("sdiv8 r", hi, 64'hFF);
    check("sdiv8 latency", 64'(lat), 64'd11);

    // Reset during cycle 20 of a running op: idle with cleared outputs next cycle.
    run_op(0, OP_SMUL, 64'd12345, 64'd678, -1, 20, lo, hi, fl, dz, lat);
    check("mid-reset busy", 64'(busy32), 64'd0);
    check("mid-reset lo", 64'(lo32), 64'd0);
    check("mid-reset hi", 64'(hi32), 64'd0);
    check("mid-reset flags", 64'(fl32), 64'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) dones++;
    end
    check("mid-reset no done", 64'(dones), 64'd0);

    // Random back-to-back operations on both widths.
    for (int i = 0; i < 80; i++) begin
      is8 = ($urandom_range(0, 1) == 1);
      o = 2'($urandom_range(0, 3));
      x = pick(is8 ? 8 : 32);
      y = pick(is8 ? 8 : 32);
      model(is8 ? 8 : 32, o, x, y, mlo, mhi, mfl, mdz);
      run_op(is8, o, x, y, -1, -1, lo, hi, fl, dz, lat);
      check("rand lo", lo, mlo);
      check("rand hi", hi, mhi);
      check("rand flags", 64'(fl), 64'(mfl));
      check("rand latency", 64'(lat), mdz ? 64'd2 : (is8 ? 64'd11 : 64'd35));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
